tcb_lite_arbiter: RTL and testbench

Shares one TCB lite subordinate between `MPN` TCB lite managers, with round-robin or fixed-priority arbitration. Request path is combinational (zero added latency). Responses return to the originating manager through a `DLY`-deep grant-index delay line matched to the subordinate's fixed response delay. Sits between CPU/DMA managers and a shared memory or peripheral crossbar port.

---
 rtl/tcb_lite_pkg.sv | 10 +
 rtl/tcb_lite_if.sv | 28 ++
 rtl/tcb_lite_arbiter_pri.sv | 27 ++
 rtl/tcb_lite_arbiter.sv | 101 ++++++++++
 tb/tb_tcb_lite_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/tcb_lite_pkg.sv
// Shared types and helpers for the TCB lite arbiter.
package tcb_lite_pkg;

  typedef enum logic {ARB_FIX, ARB_RR} arb_t;

  function automatic int arb_idx_w(input int mpn);
    return $clog2(mpn);
  endfunction

endpackage

// File: rtl/tcb_lite_if.sv
// TCB lite handshake bundle: request travels man->sub, response sub->man.
interface tcb_lite_if #(
  parameter int DAT = 32,
  parameter int ADR = DAT
) ();

  typedef struct packed {
    logic             lck;
    logic             wen;
    logic [ADR-1:0]   adr;
    logic [DAT/8-1:0] ben;
    logic [DAT-1:0]   wdt;
  } req_t;

  typedef struct packed {
    logic [DAT-1:0] rdt;
    logic           err;
  } rsp_t;

  logic vld;
  logic rdy;
  req_t req;
  rsp_t rsp;

  modport man (output vld, req, input  rdy, rsp);
  modport sub (input  vld, req, output rdy, rsp);

endinterface

// File: rtl/tcb_lite_arbiter_pri.sv
// Rotating priority encoder: first valid index at or after start, wrapping at MPN.
module tcb_lite_arbiter_pri import tcb_lite_pkg::*; #(
  parameter  int MPN = 2,
  localparam int IW  = arb_idx_w(MPN)
)(
  input  logic [MPN-1:0] vld,
  input  logic [IW-1:0]  start,
  output logic [IW-1:0]  own,
  output logic           any
);

  logic [IW-1:0] k;

  always_comb begin
    own = '0;
    any = 1'b0;
    k   = start;
    for (int i = 0; i < MPN; i++) begin
      if (!any && vld[k]) begin
        own = k;
        any = 1'b1;
      end
      k = (k == IW'(MPN-1)) ? '0 : k + 1'b1;
    end
  end

endmodule

// File: rtl/tcb_lite_arbiter.sv
// MPN-to-1 TCB lite arbiter, combinational request path, DLY-matched response routing.
// Build option TCB_LITE_ARBITER_LOCK_EN: req.lck keeps ownership across transfers.
module tcb_lite_arbiter import tcb_lite_pkg::*; #(
  parameter int   MPN = 2,
  parameter int   DLY = 1,
  parameter int   DAT = 32,
  parameter int   ADR = DAT,
  parameter arb_t PRI = ARB_RR
)(
  input  logic    clk,
  input  logic    rst,
  tcb_lite_if.sub man [MPN],
  tcb_lite_if.man sub
);

  localparam int IW    = arb_idx_w(MPN);
  localparam int REQ_W = 2 + ADR + DAT/8 + DAT;
  localparam int RSP_W = DAT + 1;

  logic [MPN-1:0]            vld_a, rdy_a;
  logic [MPN-1:0][REQ_W-1:0] req_a;
  logic [MPN-1:0][RSP_W-1:0] rsp_a;

  logic [IW-1:0] ptr, hix, start, enc_own, own, idx_out;
  logic          hld, any, trn, trn_out;

  for (genvar i = 0; i < MPN; i++) begin : g_man
    assign vld_a[i]    = man[i].vld;
    assign req_a[i]    = man[i].req;
    assign man[i].rdy  = rdy_a[i];
    assign man[i].rsp  = rsp_a[i];
  end

  assign start = (PRI == ARB_RR) ? ((ptr == IW'(MPN-1)) ? '0 : ptr + 1'b1) : '0;

  tcb_lite_arbiter_pri #(.MPN(MPN)) u_pri (
    .vld   (vld_a),
    .start (start),
    .own   (enc_own),
    .any   (any)
  );

  assign own     = hld ? hix : enc_own;
  assign sub.vld = hld ? vld_a[hix] : any;
  assign sub.req = req_a[own];
  assign trn     = sub.vld & sub.rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= IW'(MPN-1);
      hld <= 1'b0;
      hix <= '0;
    end else if (trn) begin
      ptr <= own;
`ifdef TCB_LITE_ARBITER_LOCK_EN
      hld <= sub.req.lck;
      hix <= own;
`else
      hld <= 1'b0;
`endif
    end else if (sub.vld) begin
      // stalled request must stay on the bus unchanged
      hld <= 1'b1;
      hix <= own;
    end
  end

  if (DLY == 0) begin : g_dly0
    assign trn_out = trn;
    assign idx_out = own;
  end else begin : g_dly
    logic [DLY:1]         vld_pipe;
    logic [DLY:1][IW-1:0] idx_pipe;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_pipe <= '0;
        idx_pipe <= '0;
      end else begin
        vld_pipe[1] <= trn;
        idx_pipe[1] <= own;
        for (int k = 2; k <= DLY; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          idx_pipe[k] <= idx_pipe[k-1];
        end
      end
    end

    assign trn_out = vld_pipe[DLY];
    assign idx_out = idx_pipe[DLY];
  end

  // response follows the delayed grant index, not the current owner
  always_comb begin
    for (int i = 0; i < MPN; i++) begin
      rdy_a[i] = sub.rdy & vld_a[i] & (own == IW'(i));
      rsp_a[i] = (trn_out && idx_out == IW'(i)) ? sub.rsp : 'x;
    end
  end

endmodule

// File: tb/tb_tcb_lite_arbiter.sv
// Directed bench: RR DUT (MPN=4, DLY=2) and fixed-priority DUT (MPN=4, DLY=0).
module tb_tcb_lite_arbiter;
  import tcb_lite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  tcb_lite_if #(.DAT(32)) r_man [4] ();
  tcb_lite_if #(.DAT(32)) r_sub ();
  tcb_lite_if #(.DAT(32)) f_man [4] ();
  tcb_lite_if #(.DAT(32)) f_sub ();

  logic [3:0]  r_vld, r_lck, r_rdy, f_vld, f_rdy;
  logic [31:0] r_rdt [4];
  logic [31:0] f_rdt [4];
  logic        rs_rdy, fs_rdy, r_s_vld, f_s_vld;
  logic [31:0] rs_rdt, fs_rdt, r_s_adr, f_s_adr;

  for (genvar i = 0; i < 4; i++) begin : g_m
    localparam logic [31:0] A = 32'(32'h100 + i);
    assign r_man[i].vld = r_vld[i];
    assign r_man[i].req = {r_lck[i], 1'b0, A, 4'hf, 32'h0};
    assign r_rdy[i]     = r_man[i].rdy;
    assign r_rdt[i]     = r_man[i].rsp.rdt;
    assign f_man[i].vld = f_vld[i];
    assign f_man[i].req = {1'b0, 1'b0, A, 4'hf, 32'h0};
    assign f_rdy[i]     = f_man[i].rdy;
    assign f_rdt[i]     = f_man[i].rsp.rdt;
  end

  assign r_sub.rdy = rs_rdy;
  assign r_sub.rsp = {rs_rdt, 1'b0};
  assign r_s_vld   = r_sub.vld;
  assign r_s_adr   = r_sub.req.adr;
  assign f_sub.rdy = fs_rdy;
  assign f_sub.rsp = {fs_rdt, 1'b0};
  assign f_s_vld   = f_sub.vld;
  assign f_s_adr   = f_sub.req.adr;

  tcb_lite_arbiter #(.MPN(4), .DLY(2), .DAT(32), .PRI(ARB_RR)) dut_rr (
    .clk (clk), .rst (rst), .man (r_man), .sub (r_sub)
  );

  tcb_lite_arbiter #(.MPN(4), .DLY(0), .DAT(32), .PRI(ARB_FIX)) dut_fx (
    .clk (clk), .rst (rst), .man (f_man), .sub (f_sub)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] lk_vld [4] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000};
  logic       lk_lck [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`ifdef TCB_LITE_ARBITER_LOCK_EN
  logic [31:0] lk_own [4] = '{32'h101, 32'h101, 32'h101, 32'h103};
`else
  logic [31:0] lk_own [4] = '{32'h101, 32'h103, 32'h101, 32'h103};
`endif

  initial begin
    r_vld = '0; r_lck = '0; f_vld = '0;
    rs_rdy = 1'b0; rs_rdt = '0; fs_rdy = 1'b1; fs_rdt = '0;

    // reset state
    @(negedge clk);
    chk("rst_r_vld", 32'(r_s_vld), 32'h0);
    chk("rst_r_rdy", 32'(r_rdy),   32'h0);
    chk("rst_f_vld", 32'(f_s_vld), 32'h0);
    chk("rst_f_rdy", 32'(f_rdy),   32'h0);
    nxt();
    rst = 1'b1;

    // round-robin fairness
    r_vld = 4'hf; rs_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_own", r_s_adr, 32'(32'h100 + k % 4));
      chk("rr_rdy", 32'(r_rdy), 32'(1 << (k % 4)));
      nxt();
    end

    // stall hold: manager 2 stalls, manager 0 waits
    r_vld = 4'b0100; rs_rdy = 1'b0;
    @(negedge clk);
    chk("stl_own", r_s_adr, 32'h102);
    nxt();
    r_vld = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stl_hold", r_s_adr, 32'h102);
      chk("stl_rdy0", 32'(r_rdy), 32'h0);
      nxt();
    end
    rs_rdy = 1'b1;
    @(negedge clk);
    chk("stl_xfer", r_s_adr, 32'h102);
    chk("stl_xrdy", 32'(r_rdy), 32'h4);
    nxt();
    r_vld = 4'b0001;
    @(negedge clk);
    chk("stl_next", r_s_adr, 32'h100);
    chk("stl_nrdy", 32'(r_rdy), 32'h1);
    nxt();

    // lock sequence from manager 1 against manager 3
    for (int k = 0; k < 4; k++) begin
      r_vld = lk_vld[k]; r_lck = {2'b00, lk_lck[k], 1'b0};
      @(negedge clk);
      chk("lck_own", r_s_adr, lk_own[k]);
      nxt();
    end
    r_vld = '0; r_lck = '0;
    nxt();

    // response routing, DLY=2, managers 0,3,1 back-to-back
    r_vld = 4'b0001;
    @(negedge clk); chk("rsp_g0", r_s_adr, 32'h100); nxt();
    r_vld = 4'b1000;
    @(negedge clk); chk("rsp_g3", r_s_adr, 32'h103); nxt();
    r_vld = 4'b0010; rs_rdt = 32'hA0;
    @(negedge clk);
    chk("rsp_g1",  r_s_adr,  32'h101);
    chk("rsp_m0",  r_rdt[0], 32'hA0);
    chk("rsp_m3x", r_rdt[3], 'x);
    nxt();
    r_vld = '0; rs_rdt = 32'hA3;
    @(negedge clk);
    chk("rsp_m3",  r_rdt[3], 32'hA3);
    chk("rsp_m0x", r_rdt[0], 'x);
    nxt();
    rs_rdt = 32'hA1;
    @(negedge clk);
    chk("rsp_m1",  r_rdt[1], 32'hA1);
    chk("rsp_m3y", r_rdt[3], 'x);
    nxt();

    // fixed priority with zero response delay
    f_vld = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      fs_rdt = 32'(32'hB0 + k);
      @(negedge clk);
      chk("fix_own", f_s_adr, 32'h101);
      chk("fix_rdy", 32'(f_rdy), 32'h2);
      chk("fix_rsp", f_rdt[1], 32'(32'hB0 + k));
      nxt();
    end
    f_vld = '0;

    // reset one cycle after a transfer drops its response
    r_vld = 4'b0100;
    @(negedge clk); chk("rmf_own", r_s_adr, 32'h102); nxt();
    r_vld = '0; rst = 1'b0;
    nxt();
    rst = 1'b1; rs_rdt = 32'hA2;
    @(negedge clk);
    chk("rmf_drop", r_rdt[2], 'x);
    chk("rmf_svld", 32'(r_s_vld), 32'h0);
    nxt();
    r_vld = 4'hf;
    @(negedge clk);
    chk("rmf_first", r_s_adr, 32'h100);
    nxt();
    r_vld = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
